lsu_bus_if: RTL

LSU_BUS_IF -- requirements
Module: lsu_bus_if

---
 rtl/mem_pkg.sv | 26 ++
 rtl/lsu_bus_if_if.sv | 23 ++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_bus_if.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared LSU definitions: access-size encodings, FSM state type and the default
// per-phase timeout, plus the alignment rule used by the optional misalign check.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

  // Size 2'b11 is treated as a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_BYTE: return 1'b0;
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_if_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface lsu_bus_if_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Lane logic for the LSU: byte strobes, store-data replication and load
// lane extraction with sign/zero extension. Purely combinational.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte   = rdata[{addr_lo, 3'b000} +: 8];
    rd_half   = rdata[{addr_lo[1], 4'b0000} +: 16];
    be        = 4'b1111;
    wdata_rep = wdata;
    ld_ext    = rdata;
    case (size)
      SZ_HALF: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        ld_ext    = load_unsigned ? {16'h0000, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        ld_ext    = load_unsigned ? {24'h000000, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_if.sv
// LSU data-bus adapter: IDLE/REQ/RESP handshake with an 8-bit per-phase wait timeout.
// Define LSU_MISALIGN_CHECK_EN to abort misaligned half/word accesses without a bus cycle.
module lsu_bus_if
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_rd_en,
  input  logic         MemW,
  input  logic [1:0]   data_length,
  input  logic         load_unsigned,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  ld_data,
  output logic         ld_valid,
  output logic         st_done,
  output logic         busy,
  output logic         err,
  lsu_bus_if_if.master bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e  state, state_nxt;
  logic [7:0]  cnt;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        start, misalign, stalled, timeout;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc, ld_calc;

  assign start = MemW | mem_rd_en;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(data_length, addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign stalled = ((state == ST_REQ) && !bus.bus_gnt) || ((state == ST_RESP) && !bus.bus_rvalid);
  assign timeout = stalled && (cnt == TO_LAST);

  lsu_align u_align (
    .size          (size_q),
    .addr_lo       (addr_q[1:0]),
    .load_unsigned (uns_q),
    .wdata         (wdata_q),
    .rdata         (bus.bus_rdata),
    .be            (be_calc),
    .wdata_rep     (wdata_calc),
    .ld_ext        (ld_calc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && !misalign) state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.bus_gnt)  state_nxt = we_q ? ST_IDLE : ST_RESP;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_RESP: if (bus.bus_rvalid || timeout) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus fields are only driven while requesting; they read zero otherwise.
  always_comb begin
    busy          = (state != ST_IDLE);
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 32'h0;
    bus.bus_be    = 4'h0;
    bus.bus_wdata = 32'h0;
    if (state == ST_REQ) begin
      bus.bus_req   = 1'b1;
      bus.bus_we    = we_q;
      bus.bus_addr  = {addr_q[31:2], 2'b00};
      bus.bus_be    = be_calc;
      bus.bus_wdata = wdata_calc;
    end
  end

  // Access attributes are captured once; requests while busy never reach here.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start && !misalign) begin
      we_q    <= MemW;
      size_q  <= data_length;
      uns_q   <= load_unsigned;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 8'h00;
      ld_data  <= 32'h0;
      ld_valid <= 1'b0;
      st_done  <= 1'b0;
      err      <= 1'b0;
    end else begin
      ld_valid <= 1'b0;
      st_done  <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= 8'h00;
          if (start && misalign) err <= 1'b1;
        end
        ST_REQ: begin
          if (bus.bus_gnt) begin
            st_done <= we_q;
            cnt     <= 8'h00;
          end else if (timeout) begin
            err <= 1'b1;
            cnt <= 8'h00;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          if (bus.bus_rvalid) begin
            ld_data  <= ld_calc;
            ld_valid <= 1'b1;
            cnt      <= 8'h00;
          end else if (timeout) begin
            err <= 1'b1;
            cnt <= 8'h00;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: cnt <= 8'h00;
      endcase
    end
  end

endmodule
